uart_rx_buffer: RTL and testbench
=================================

# uart_rx_buffer

Memory-mapped receive buffer sitting directly downstream of the UART receiver in the single-cycle MIPS peripheral space. Detects each completed frame from the receiver's finish strobe, captures the received byte into a small FIFO, and presents RX data/status registers to the CPU load/store path. Also drives the receiver's enable and, optionally, a receive interrupt.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..16
- ADDR_RXD, 32'h4000_001C, RX data register address (read pops)
- ADDR_CON, 32'h4000_0020, UART control/status register address
- sysclk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rx_fin  in  1  receiver frame-finish level (not sysclk-synchronous)
- rx_data  in  8  receiver byte, stable while rx_fin high
- rx_enable  out  1  drives receiver enable; reset value 1
- rd  in  1  CPU memory read
- wr  in  1  CPU memory write
- addr  in  32  CPU byte address
- wdata  in  32  CPU write data
- rdata  out  32  combinational read data; 0 when no address hit or rd low
- irq  out  1  receive interrupt; reset value 0

## Operation
- rx_fin passes a 2-flop synchronizer, then a third flop for edge detect; push = sync2 & ~sync3.
- Push writes rx_data into FIFO at wr_ptr; wr_ptr increments modulo DEPTH; count increments.
- Read of ADDR_RXD: rdata = {24'b0, head byte}; pop on the rising edge where rd & addr hit; rd_ptr increments modulo DEPTH.
- Read of ADDR_RXD when empty: rdata = 0, no pointer/count change.
- Push when full and no pop: byte dropped, overrun flag set (sticky).
- Push and pop same edge: both take effect, count unchanged (including full and empty cases; empty case returns 0 and count becomes 1).
- ADDR_CON read: bit0 rx_en, bit1 irq_en, bit2 not_empty, bit3 overrun, bits[11:8] count, others 0.
- ADDR_CON write: bit0 -> rx_en, bit1 -> irq_en, bit3 write-1-clears overrun; overrun set by same-edge drop wins over clear.
- Writes to ADDR_RXD ignored. rd and wr together on ADDR_CON: read returns pre-write value.
- rx_enable = rx_en. Clearing rx_en does not flush FIFO; pushes still accepted.

## Timing
- rx_fin first sampled high at edge k: byte in FIFO and count updated at edge k+2; visible in rdata after edge k+2.
- rx_fin must stay high ≥3 sysclk cycles; one push per rising transition regardless of high duration.
- Pop: count/status reflect pop after the same edge; next head available combinationally.
- Reset values: pointers 0, count 0, overrun 0, rx_en 1, irq_en 0, sync flops 0, irq 0, rdata 0.
- Reset asserted mid-frame: synchronizer cleared; a rx_fin still high after reset release produces one push (sync3 starts at 0).

## Configuration
- UART_RX_IRQ_EN defined: irq register updated each edge to irq_en & not_empty (one cycle after state change).
- Undefined: irq tied 0, CON bit1 reads 0 and writes ignored.

## Structure
- Package uart_rx_pkg: ADDR_RXD/ADDR_CON defaults, CON bit-position constants, default DEPTH.
- Sub-module uart_rx_fifo: pointers, count, storage, full/empty; parent holds synchronizer, registers, bus decode.

## Test plan
- Reset, then read ADDR_CON -> rdata = 32'h0000_0001, rx_enable = 1, irq = 0.
- Pulse rx_fin 5 cycles with rx_data 8'hA5 -> count 1 after edge k+2; read ADDR_RXD -> 32'h0000_00A5, then count 0.
- Push 9 bytes 0x01..0x09 with DEPTH 8 -> count 8, overrun 1; reads return 0x01..0x08 then 0; write CON 32'h0000_0009 clears overrun.
- FIFO full, push and RXD read same edge -> returns oldest byte, count stays 8, overrun 0.
- UART_RX_IRQ_EN defined: write CON 32'h3, push 0x5A -> irq 1 one cycle after push; read RXD -> irq 0 one cycle later.
- Assert reset with 3 bytes queued -> count 0, RXD read returns 0, rx_enable 1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants for the UART receive buffer
package uart_rx_pkg;

    localparam int          UART_DEFAULT_DEPTH = 8;
    localparam logic [31:0] UART_ADDR_RXD      = 32'h4000_001C;
    localparam logic [31:0] UART_ADDR_CON      = 32'h4000_0020;

    // Control/status register bit positions
    localparam int CON_RX_EN     = 0;
    localparam int CON_IRQ_EN    = 1;
    localparam int CON_NOT_EMPTY = 2;
    localparam int CON_OVERRUN   = 3;
    localparam int CON_COUNT_LSB = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO holding received UART frames
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_head,
    output logic [4:0] o_count,
    output logic       o_empty,
    output logic       o_drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == 5'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - memory-mapped UART receive buffer; UART_RX_IRQ_EN adds the receive interrupt
import uart_rx_pkg::*;

module uart_rx_buffer #(
    parameter int          DEPTH    = UART_DEFAULT_DEPTH,
    parameter logic [31:0] ADDR_RXD = UART_ADDR_RXD,
    parameter logic [31:0] ADDR_CON = UART_ADDR_CON
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rx_fin,
    input  logic [7:0]  rx_data,
    output logic        rx_enable,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic        r_rx_en;
    logic        r_overrun;
    logic        w_push;
    logic        w_rd_rxd;
    logic        w_rd_con;
    logic        w_wr_con;
    logic        w_drop;
    logic        w_empty;
    logic        w_irq_en;
    logic [7:0]  w_head;
    logic [4:0]  w_count;
    logic [31:0] w_con;
    logic        w_unused;

    // rx_fin is asynchronous to sysclk: two flops to synchronize, a third for the edge
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= rx_fin;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_push   = r_sync2 & ~r_sync3;
    assign w_rd_rxd = rd & (addr == ADDR_RXD);
    assign w_rd_con = rd & (addr == ADDR_CON);
    assign w_wr_con = wr & (addr == ADDR_CON);

    uart_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk   (sysclk),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_pop   (w_rd_rxd),
        .i_data  (rx_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rx_en   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_con) begin
                r_rx_en <= wdata[CON_RX_EN];
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_wr_con && wdata[CON_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_con) begin
                r_irq_en <= wdata[CON_IRQ_EN];
            end
            r_irq <= r_irq_en & ~w_empty;
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        w_con                       = '0;
        w_con[CON_RX_EN]            = r_rx_en;
        w_con[CON_IRQ_EN]           = w_irq_en;
        w_con[CON_NOT_EMPTY]        = ~w_empty;
        w_con[CON_OVERRUN]          = r_overrun;
        w_con[CON_COUNT_LSB +: 4]   = w_count[3:0];
    end

    always_comb begin
        rdata = '0;
        if (w_rd_rxd) begin
            if (!w_empty) begin
                rdata = {24'b0, w_head};
            end
        end else if (w_rd_con) begin
            rdata = w_con;
        end
    end

    assign rx_enable = r_rx_en;
    assign w_unused  = ^{wdata[31:4], wdata[2:1], w_count[4]};

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - randomized self-checking bench for uart_rx_buffer against a queue model
module tb_uart_rx_buffer;
    import uart_rx_pkg::*;

    localparam int DEPTH = 8;
`ifdef UART_RX_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        sysclk = 1'b0;
    logic        reset;
    logic        rx_fin;
    logic [7:0]  rx_data;
    logic        rx_enable;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    uart_rx_buffer #(.DEPTH(DEPTH)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rx_fin    (rx_fin),
        .rx_data   (rx_data),
        .rx_enable (rx_enable),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q[$];
    logic       m_ovr;
    logic       m_rxen;
    logic       m_irqen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [31:0] model_con();
        logic [31:0] v;
        v       = '0;
        v[0]    = m_rxen;
        v[1]    = m_irqen;
        v[2]    = (m_q.size() != 0);
        v[3]    = m_ovr;
        v[11:8] = 4'(m_q.size());
        return v;
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr   = 1'b0;
        m_rxen  = 1'b1;
        m_irqen = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        rd   = 1'b1;
        addr = a;
        #1;
        d    = rdata;
        rd   = 1'b0;
        addr = '0;
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [31:0] d;
        peek(UART_ADDR_CON, d);
        check({tag, "_con"}, d, model_con());
        check({tag, "_rxen"}, {31'b0, rx_enable}, {31'b0, m_rxen});
    endtask

    task automatic read_rxd(input string tag);
        logic [31:0] exp;
        exp  = (m_q.size() != 0) ? {24'b0, m_q[0]} : 32'h0;
        rd   = 1'b1;
        addr = UART_ADDR_RXD;
        #2;
        check(tag, rdata, exp);
        tick();
        rd   = 1'b0;
        addr = '0;
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic write_con(input logic [31:0] d);
        wr    = 1'b1;
        addr  = UART_ADDR_CON;
        wdata = d;
        tick();
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        m_rxen = d[0];
        if (IRQ_BUILD) m_irqen = d[1];
        if (d[3]) m_ovr = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_fin  = 1'b1;
        repeat (hold) tick();
        rx_fin  = 1'b0;
        repeat (3) tick();
        model_push(b);
    endtask

    task automatic drain();
        while (m_q.size() != 0) read_rxd("drain");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] w;
        logic [31:0] pre;

        reset = 1'b1; rx_fin = 1'b0; rx_data = '0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check_state("reset");
        check("reset_irq", {31'b0, irq}, 32'h0);
        addr = UART_ADDR_CON;
        #1;
        check("rd_low_rdata", rdata, 32'h0);
        addr = '0;

        // first-frame latency: count must move exactly at the third sampling edge
        rx_data = 8'hA5;
        rx_fin  = 1'b1;
        tick();
        tick();
        check_state("lat_k1");
        tick();
        m_q.push_back(8'hA5);
        check_state("lat_k2");
        repeat (2) tick();
        rx_fin = 1'b0;
        repeat (3) tick();
        read_rxd("rxd_a5");
        check_state("after_a5");

        for (int i = 1; i <= 9; i++) push_byte(8'(i), 3);
        check_state("overflow");
        for (int i = 0; i < 9; i++) read_rxd("ovf_read");
        check_state("ovf_drained");
        write_con(32'h0000_0009);
        check_state("ovr_clear");

        // full FIFO: push and RXD pop land on the same edge
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 3);
        rx_data = 8'hC3;
        rx_fin  = 1'b1;
        tick();
        tick();
        rd = 1'b1; addr = UART_ADDR_RXD;
        #2;
        check("full_same_edge_rd", rdata, {24'b0, m_q[0]});
        tick();
        rd = 1'b0; addr = '0;
        void'(m_q.pop_front());
        m_q.push_back(8'hC3);
        check_state("full_same_edge");
        rx_fin = 1'b0;
        repeat (3) tick();
        drain();

        // empty FIFO: same-edge read returns 0 and the push still lands
        rx_data = 8'h7E;
        rx_fin  = 1'b1;
        tick();
        tick();
        rd = 1'b1; addr = UART_ADDR_RXD;
        #2;
        check("empty_same_edge_rd", rdata, 32'h0);
        tick();
        rd = 1'b0; addr = '0;
        m_q.push_back(8'h7E);
        check_state("empty_same_edge");
        rx_fin = 1'b0;
        repeat (3) tick();
        drain();

        // overrun set by a drop wins over a same-edge clear
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 3);
        rx_data = 8'hEE;
        rx_fin  = 1'b1;
        tick();
        tick();
        wr = 1'b1; addr = UART_ADDR_CON; wdata = 32'h9;
        tick();
        wr = 1'b0; addr = '0; wdata = '0;
        m_ovr = 1'b1;
        check_state("drop_beats_clear");
        rx_fin = 1'b0;
        repeat (3) tick();
        write_con(32'h9);
        check_state("ovr_clear2");
        drain();

        push_byte(8'h3C, 12);
        check_state("long_hold");
        read_rxd("long_hold_rd");

        write_con(32'h0);
        push_byte(8'h42, 4);
        check_state("rx_disabled_push");
        read_rxd("rx_disabled_rd");
        write_con(32'h1);

        // simultaneous read and write of CON returns the pre-write value
        pre = model_con();
        rd = 1'b1; wr = 1'b1; addr = UART_ADDR_CON; wdata = 32'h0;
        #2;
        check("con_rd_wr", rdata, pre);
        tick();
        rd = 1'b0; wr = 1'b0; addr = '0;
        m_rxen = 1'b0;
        check_state("con_after_rw");
        write_con(32'h1);

        wr = 1'b1; addr = UART_ADDR_RXD; wdata = 32'hFF;
        tick();
        wr = 1'b0; addr = '0; wdata = '0;
        check_state("rxd_write_ignored");

        write_con(32'h3);
        rx_data = 8'h5A;
        rx_fin  = 1'b1;
        repeat (3) tick();
        check("irq_pre", {31'b0, irq}, 32'h0);
        tick();
        check("irq_set", {31'b0, irq}, {31'b0, IRQ_BUILD});
        rx_fin = 1'b0;
        repeat (3) tick();
        m_q.push_back(8'h5A);
        read_rxd("irq_rd");
        check("irq_hold", {31'b0, irq}, {31'b0, IRQ_BUILD});
        tick();
        check("irq_clear", {31'b0, irq}, 32'h0);
        write_con(32'h1);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 4))
                0, 1: push_byte(8'($urandom), $urandom_range(3, 6));
                2, 3: read_rxd("rnd_rxd");
                default: begin
                    w    = $urandom;
                    w[0] = ($urandom_range(0, 7) != 0);
                    write_con(w);
                end
            endcase
            check_state("rnd");
        end
        drain();
        write_con(32'h9);

        for (int i = 0; i < 3; i++) push_byte(8'($urandom), 3);
        reset = 1'b1;
        model_reset();
        #1;
        check_state("async_reset");
        tick();
        reset = 1'b0;
        tick();
        read_rxd("reset_rxd_empty");
        check_state("post_reset");

        // reset mid-frame: rx_fin still high afterwards yields exactly one push
        rx_data = 8'h99;
        rx_fin  = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_state("midframe_before");
        tick();
        m_q.push_back(8'h99);
        check_state("midframe_push");
        repeat (3) tick();
        rx_fin = 1'b0;
        repeat (4) tick();
        check_state("midframe_single");
        read_rxd("midframe_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
